// File: rtl/pipe_flow_ctrl_if.sv
// Control bundle between the pipeline datapath and its flow controller.
// master = flow controller, slave = datapath / pipeline registers.
interface pipe_flow_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic             ex_br_taken;
  logic             ex_jal;
  logic             ex_jalr;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic [4:0]       de_rs1;
  logic [4:0]       de_rs2;
  logic [1:0]       de_use_rs;
  logic             mem_busy;

  logic [1:0]       pc_sel;
  logic             pc_en;
  logic             imem_rden;
  logic             if_de_en;
  logic             if_de_flush;
  logic             de_ex_en;
  logic             de_ex_flush;
  logic             ex_mem_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  ex_valid, ex_br_taken, ex_jal, ex_jalr, ex_mem_read,
           ex_rd, de_rs1, de_rs2, de_use_rs, mem_busy,
    output pc_sel, pc_en, imem_rden, if_de_en, if_de_flush,
           de_ex_en, de_ex_flush, ex_mem_en, stall_cnt, flush_cnt
  );

  modport slave (
    output ex_valid, ex_br_taken, ex_jal, ex_jalr, ex_mem_read,
           ex_rd, de_rs1, de_rs2, de_use_rs, mem_busy,
    input  pc_sel, pc_en, imem_rden, if_de_en, if_de_flush,
           de_ex_en, de_ex_flush, ex_mem_en, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: PC select/enable, IMEM enable, stage enables/flushes, perf counters.
// Latency: control outputs are combinational (0 cycles); state and counters update on core clock.
// Backpressure: mem_busy freezes every stage and the PC; a pending redirect is taken once it drops.
module pipe_flow_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic            clk,
  input logic            rst_n,
  pipe_flow_ctrl_if.master pif
);

  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              stall_inc, flush_inc;
  logic              redirect, load_use;
  logic              rs1_hit, rs2_hit;

  assign redirect = pif.ex_valid & (pif.ex_jalr | pif.ex_jal | pif.ex_br_taken);
  assign rs1_hit  = pif.de_use_rs[0] & (pif.de_rs1 == pif.ex_rd);
  assign rs2_hit  = pif.de_use_rs[1] & (pif.de_rs2 == pif.ex_rd);
  assign load_use = pif.ex_valid & pif.ex_mem_read & (pif.ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    pif.pc_sel      = 2'b00;
    pif.pc_en       = 1'b1;
    pif.imem_rden   = 1'b1;
    pif.if_de_en    = 1'b1;
    pif.if_de_flush = 1'b0;
    pif.de_ex_en    = 1'b1;
    pif.de_ex_flush = 1'b0;
    pif.ex_mem_en   = 1'b1;

    if (!rst_n) begin
      // Hold everything still and bubble both front registers while in reset.
      pif.pc_en       = 1'b0;
      pif.imem_rden   = 1'b0;
      pif.if_de_en    = 1'b0;
      pif.de_ex_en    = 1'b0;
      pif.ex_mem_en   = 1'b0;
      pif.if_de_flush = 1'b1;
      pif.de_ex_flush = 1'b1;
    end else if (pif.mem_busy) begin
      pif.pc_en     = 1'b0;
      pif.imem_rden = 1'b0;
      pif.if_de_en  = 1'b0;
      pif.de_ex_en  = 1'b0;
      pif.ex_mem_en = 1'b0;
      stall_inc     = 1'b1;
    end else if (state_q == BOOT) begin
      // Synchronous IMEM has nothing valid on its output yet.
      pif.if_de_flush = 1'b1;
      state_d         = RUN;
    end else if (redirect) begin
      pif.pc_sel      = pif.ex_jalr ? 2'b01 : (pif.ex_jal ? 2'b11 : 2'b10);
      pif.if_de_flush = 1'b1;
      pif.de_ex_flush = 1'b1;
      flush_inc       = 1'b1;
      if (FLUSH_CYCLES == 0) begin
        state_d = RUN;
      end else begin
        state_d = FLUSH;
        fcnt_d  = FC_W'(FLUSH_CYCLES);
      end
    end else if (state_q == FLUSH) begin
      pif.if_de_flush = 1'b1;
      fcnt_d          = fcnt_q - FC_W'(1);
      if (fcnt_q <= FC_W'(1)) state_d = RUN;
    end else if (load_use) begin
      // One bubble into EX; the stalled consumer re-evaluates against that bubble next cycle.
      pif.pc_en       = 1'b0;
      pif.imem_rden   = 1'b0;
      pif.if_de_en    = 1'b0;
      pif.de_ex_flush = 1'b1;
      stall_inc       = 1'b1;
    end
  end

  assign pif.stall_cnt = stall_cnt_q;
  assign pif.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Scoreboarded bench for pipe_flow_ctrl: a 32-bit counter instance and a 4-bit counter
// instance see identical stimulus; expectations are queued per cycle and checked at negedge.
module tb_pipe_flow_ctrl;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       pc_en;
    logic       imem_rden;
    logic       if_de_en;
    logic       if_de_flush;
    logic       de_ex_en;
    logic       de_ex_flush;
    logic       ex_mem_en;
  } ctl_t;

  typedef struct {
    ctl_t  ctl;
    int    stall;
    int    flush;
    string name;
  } exp_t;

  localparam ctl_t NORM = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctl_t RSTV = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctl_t FLSH = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctl_t FRZ  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t LU   = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctl_t RBR  = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctl_t RJR  = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctl_t RJL  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  pipe_flow_ctrl_if #(.CNT_W(32)) pif ();
  pipe_flow_ctrl_if #(.CNT_W(4))  pif4 ();

  assign pif4.ex_valid    = pif.ex_valid;
  assign pif4.ex_br_taken = pif.ex_br_taken;
  assign pif4.ex_jal      = pif.ex_jal;
  assign pif4.ex_jalr     = pif.ex_jalr;
  assign pif4.ex_mem_read = pif.ex_mem_read;
  assign pif4.ex_rd       = pif.ex_rd;
  assign pif4.de_rs1      = pif.de_rs1;
  assign pif4.de_rs2      = pif.de_rs2;
  assign pif4.de_use_rs   = pif.de_use_rs;
  assign pif4.mem_busy    = pif.mem_busy;

  pipe_flow_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut   (.clk(clk), .rst_n(rst_n), .pif(pif.master));
  pipe_flow_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .pif(pif4.master));

  initial forever #5 clk = ~clk;

  // Monitor: every cycle presents a control vector, so one expectation is consumed per negedge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      ctl_t act;
      logic [3:0] e4s, e4f;
      e   = sb.pop_front();
      act = '{pif.pc_sel, pif.pc_en, pif.imem_rden, pif.if_de_en, pif.if_de_flush,
              pif.de_ex_en, pif.de_ex_flush, pif.ex_mem_en};
      e4s = (e.stall > 15) ? 4'hF : 4'(e.stall);
      e4f = (e.flush > 15) ? 4'hF : 4'(e.flush);
      tests++;
      if (act !== e.ctl) begin
        fails++;
        $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      tests++;
      if (pif.stall_cnt !== 32'(e.stall) || pif.flush_cnt !== 32'(e.flush)) begin
        fails++;
        $display("FAIL %s cnt32: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, pif.stall_cnt, pif.flush_cnt, e.stall, e.flush);
      end
      tests++;
      if (pif4.stall_cnt !== e4s || pif4.flush_cnt !== e4f) begin
        fails++;
        $display("FAIL %s cnt4: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, pif4.stall_cnt, pif4.flush_cnt, e4s, e4f);
      end
    end
  end

  task automatic clr();
    pif.ex_valid    = 1'b0;
    pif.ex_br_taken = 1'b0;
    pif.ex_jal      = 1'b0;
    pif.ex_jalr     = 1'b0;
    pif.ex_mem_read = 1'b0;
    pif.ex_rd       = 5'd0;
    pif.de_rs1      = 5'd0;
    pif.de_rs2      = 5'd0;
    pif.de_use_rs   = 2'b00;
    pif.mem_busy    = 1'b0;
  endtask

  task automatic cyc(input ctl_t c, input int st, input int fl, input string nm);
    exp_t e;
    e.ctl   = c;
    e.stall = st;
    e.flush = fl;
    e.name  = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // 1: reset, BOOT bubble, then normal flow
    for (int i = 0; i < 3; i++) cyc(RSTV, 0, 0, "reset");
    rst_n = 1'b1;
    cyc(FLSH, 0, 0, "boot");
    cyc(NORM, 0, 0, "run_idle");

    // 2: taken branch, one extra IF/DE flush cycle
    pif.ex_valid = 1'b1; pif.ex_br_taken = 1'b1;
    cyc(RBR, 0, 0, "br_redirect");
    clr();
    cyc(FLSH, 0, 1, "br_flush");
    cyc(NORM, 0, 1, "br_after");
    pif.ex_br_taken = 1'b1;
    cyc(NORM, 0, 1, "br_not_valid");
    clr();

    // 3: load-use on rs2 and rs1, no stall for x0 or unused operand
    pif.ex_valid = 1'b1; pif.ex_mem_read = 1'b1; pif.ex_rd = 5'd5;
    pif.de_rs2 = 5'd5; pif.de_use_rs = 2'b10;
    cyc(LU, 0, 1, "lu_rs2");
    clr();
    cyc(NORM, 1, 1, "lu_after");
    pif.ex_valid = 1'b1; pif.ex_mem_read = 1'b1; pif.ex_rd = 5'd0;
    pif.de_rs2 = 5'd0; pif.de_use_rs = 2'b10;
    cyc(NORM, 1, 1, "lu_x0");
    pif.ex_rd = 5'd7; pif.de_rs1 = 5'd7; pif.de_use_rs = 2'b10;
    cyc(NORM, 1, 1, "lu_rs1_unused");
    pif.de_use_rs = 2'b01;
    cyc(LU, 1, 1, "lu_rs1");
    clr();
    cyc(NORM, 2, 1, "lu_rs1_after");

    // 4: jalr held behind a 4-cycle memory freeze
    pif.ex_valid = 1'b1; pif.ex_jalr = 1'b1; pif.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc(FRZ, 2 + i, 1, "jalr_frozen");
    pif.mem_busy = 1'b0;
    cyc(RJR, 6, 1, "jalr_redirect");
    clr();
    // jal in FLUSH re-redirects; freeze inside FLUSH holds the state
    pif.ex_valid = 1'b1; pif.ex_jal = 1'b1;
    cyc(RJL, 6, 2, "jal_in_flush");
    clr();
    pif.mem_busy = 1'b1;
    cyc(FRZ, 6, 3, "flush_frozen");
    pif.mem_busy = 1'b0;
    cyc(FLSH, 7, 3, "flush_resume");
    cyc(NORM, 7, 3, "flush_done");

    // 5: jal + branch + load-use match: redirect wins, no stall
    pif.ex_valid = 1'b1; pif.ex_jal = 1'b1; pif.ex_br_taken = 1'b1;
    pif.ex_mem_read = 1'b1; pif.ex_rd = 5'd9; pif.de_rs1 = 5'd9; pif.de_use_rs = 2'b01;
    cyc(RJL, 7, 3, "jal_over_lu");
    clr();
    cyc(FLSH, 7, 4, "jal_flush");
    cyc(NORM, 7, 4, "jal_after");

    // 6: 20 freeze cycles saturate the 4-bit counter; reset mid-FLUSH
    pif.mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) cyc(FRZ, 7 + i, 4, "long_freeze");
    pif.mem_busy = 1'b0;
    pif.ex_valid = 1'b1; pif.ex_br_taken = 1'b1;
    cyc(RBR, 27, 4, "sat_redirect");
    clr();
    rst_n = 1'b0;
    cyc(RSTV, 0, 0, "reset_mid_flush");
    cyc(RSTV, 0, 0, "reset_hold");
    rst_n = 1'b1;
    cyc(FLSH, 0, 0, "boot_again");
    cyc(NORM, 0, 0, "run_again");

    // BOOT held by a memory freeze
    rst_n = 1'b0;
    cyc(RSTV, 0, 0, "reset3");
    rst_n = 1'b1;
    pif.mem_busy = 1'b1;
    cyc(FRZ, 0, 0, "boot_frozen");
    cyc(FRZ, 1, 0, "boot_frozen");
    pif.mem_busy = 1'b0;
    cyc(FLSH, 2, 0, "boot_released");
    cyc(NORM, 2, 0, "boot_run");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
